// File: rtl/qdec_pkg.sv
// qdec_pkg: shared phase-state constants, direction codes and up-sequence helper for quad_decoder
package qdec_pkg;
  localparam logic [1:0] AB_00 = 2'b00;
  localparam logic [1:0] AB_10 = 2'b10;
  localparam logic [1:0] AB_11 = 2'b11;
  localparam logic [1:0] AB_01 = 2'b01;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;
  function automatic logic [1:0] next_up(input logic [1:0] ab);
    return ab == AB_00 ? AB_10 : ab == AB_10 ? AB_11 : ab == AB_11 ? AB_01 : AB_00;
  endfunction
endpackage

// File: rtl/quad_decoder_if.sv
// quad_decoder_if: encoder phases, control and position/status outputs of the quadrature decoder
interface quad_decoder_if #(parameter int WIDTH = 8);
  logic a_in;
  logic b_in;
  logic en;
  logic load;
  logic [WIDTH-1:0] load_val;
  logic err_clr;
  logic [WIDTH-1:0] pos;
  logic step;
  logic dir;
  logic err;
  modport master (output a_in, b_in, en, load, load_val, err_clr, input pos, step, dir, err);
  modport slave (input a_in, b_in, en, load, load_val, err_clr, output pos, step, dir, err);
endinterface

// File: rtl/qdec_sync.sv
// qdec_sync: 2-flop synchronizer for one encoder phase, plus a stability filter when QDEC_FILTER_EN is defined
module qdec_sync #(
`ifdef QDEC_FILTER_EN
  parameter int FILT_LEN = 4
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic s1, s2;
  // two-stage metastability guard on the asynchronous pin
  always_ff @(posedge clk or posedge reset)
    if (reset) {s1, s2} <= 2'b00;
    else {s1, s2} <= {d, s1};
`ifdef QDEC_FILTER_EN
  localparam int CW = $clog2(FILT_LEN + 1);
  logic [CW-1:0] cnt;
  // accept a new level only after it has differed from q for FILT_LEN consecutive cycles
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      q <= 1'b0;
    end else if (s2 == q) cnt <= '0;
    else if (cnt == CW'(FILT_LEN - 1)) begin
      cnt <= '0;
      q <= s2;
    end else cnt <= cnt + 1'b1;
`else
  assign q = s2;
`endif
endmodule

// File: rtl/quad_decoder.sv
// quad_decoder: A/B quadrature decoder with step/dir pulses, wrapping position and sticky error (QDEC_FILTER_EN adds glitch filters)
module quad_decoder
  import qdec_pkg::*;
#(
  parameter int WIDTH = 8
`ifdef QDEC_FILTER_EN
  , parameter int FILT_LEN = 4
`endif
) (
  input logic clk,
  input logic reset,
  quad_decoder_if.slave bus
);
  logic a_s, b_s;
  logic [1:0] ab, prev_ab, prime_cnt;
  logic primed, act, is_up, is_dn, is_ill;
`ifdef QDEC_FILTER_EN
  qdec_sync #(.FILT_LEN(FILT_LEN)) u_sync_a (.clk(clk), .reset(reset), .d(bus.a_in), .q(a_s));
  qdec_sync #(.FILT_LEN(FILT_LEN)) u_sync_b (.clk(clk), .reset(reset), .d(bus.b_in), .q(b_s));
`else
  qdec_sync u_sync_a (.clk(clk), .reset(reset), .d(bus.a_in), .q(a_s));
  qdec_sync u_sync_b (.clk(clk), .reset(reset), .d(bus.b_in), .q(b_s));
`endif
  assign ab = {a_s, b_s};
  // classify the phase change against the previous sample
  always_comb begin
    act = primed & bus.en;
    is_up = ab == next_up(prev_ab);
    is_dn = prev_ab == next_up(ab);
    is_ill = (ab != prev_ab) & ~is_up & ~is_dn;
  end
  // priming window, position counter, direction, step pulse and sticky error
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bus.pos <= '0;
      bus.step <= 1'b0;
      bus.dir <= DIR_UP;
      bus.err <= 1'b0;
      prev_ab <= AB_00;
      prime_cnt <= 2'd0;
      primed <= 1'b0;
    end else begin
      prev_ab <= ab;
      bus.step <= act & (is_up | is_dn);
      if (act & (is_up | is_dn)) bus.dir <= is_up ? DIR_UP : DIR_DN;
      bus.err <= (act & is_ill) | (bus.err & ~bus.err_clr);
      bus.pos <= bus.load ? bus.load_val : act & is_up ? bus.pos + 1'b1 : act & is_dn ? bus.pos - 1'b1 : bus.pos;
      if (!primed) begin
        prime_cnt <= prime_cnt + 2'd1;
        primed <= prime_cnt == 2'd2;
      end
    end
endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: directed scoreboard bench for quad_decoder (filter-aware when QDEC_FILTER_EN is defined)
module tb_quad_decoder;
  localparam int W = 8;
`ifdef QDEC_FILTER_EN
  localparam int LAT = 3 + 4;
`else
  localparam int LAT = 3;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  quad_decoder_if #(.WIDTH(W)) qif ();
  quad_decoder #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(qif));
  typedef struct {
    string tag;
    logic step;
    logic dir;
    logic [W-1:0] pos;
    logic err;
  } exp_t;
  exp_t sb[$];
  int n_vec = 0;
  int n_bad = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic pop_check();
    exp_t e;
    e = sb.pop_front();
    chk({e.tag, ".step"}, 32'(qif.step), 32'(e.step));
    chk({e.tag, ".dir"}, 32'(qif.dir), 32'(e.dir));
    chk({e.tag, ".pos"}, 32'(qif.pos), 32'(e.pos));
    chk({e.tag, ".err"}, 32'(qif.err), 32'(e.err));
  endtask
  task automatic move(input logic a, input logic b, input logic st, input logic d,
                      input logic [W-1:0] p, input logic e, input logic clr, input string tag);
    @(negedge clk);
    qif.a_in = a;
    qif.b_in = b;
    sb.push_back('{tag, st, d, p, e});
    repeat (LAT - 1) @(posedge clk);
    #1;
    qif.err_clr = clr;
    @(posedge clk);
    #1;
    qif.err_clr = 1'b0;
    pop_check();
    @(posedge clk);
    #1;
    chk({tag, ".pulse_end"}, 32'(qif.step), 32'd0);
  endtask
  task automatic do_load(input logic [W-1:0] v, input string tag);
    @(negedge clk);
    qif.load = 1'b1;
    qif.load_val = v;
    @(posedge clk);
    #1;
    qif.load = 1'b0;
    chk(tag, 32'(qif.pos), 32'(v));
  endtask
  initial begin
    qif.a_in = 1'b0;
    qif.b_in = 1'b0;
    qif.en = 1'b1;
    qif.load = 1'b0;
    qif.load_val = '0;
    qif.err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.pos", 32'(qif.pos), 32'd0);
    chk("rst.step", 32'(qif.step), 32'd0);
    chk("rst.dir", 32'(qif.dir), 32'd1);
    chk("rst.err", 32'(qif.err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    move(1, 0, 1, 1, 8'd1, 0, 0, "up1");
    move(1, 1, 1, 1, 8'd2, 0, 0, "up2");
    move(0, 1, 1, 1, 8'd3, 0, 0, "up3");
    move(0, 0, 1, 1, 8'd4, 0, 0, "up4");
    move(1, 0, 1, 1, 8'd5, 0, 0, "up5");
    move(1, 1, 1, 1, 8'd6, 0, 0, "up6");
    move(0, 1, 1, 1, 8'd7, 0, 0, "up7");
    move(0, 0, 1, 1, 8'd8, 0, 0, "up8");
    do_load(8'h01, "load01");
    move(0, 1, 1, 0, 8'h00, 0, 0, "dn1");
    move(1, 1, 1, 0, 8'hFF, 0, 0, "dn_wrap");
    do_load(8'hFF, "loadFF");
    move(0, 1, 1, 1, 8'h00, 0, 0, "up_wrap");
    move(0, 0, 1, 1, 8'h01, 0, 0, "up9");
    move(1, 1, 0, 1, 8'h01, 1, 0, "illegal1");
    move(0, 0, 0, 1, 8'h01, 1, 1, "illegal_clr");
    @(negedge clk);
    qif.err_clr = 1'b1;
    @(posedge clk);
    #1;
    qif.err_clr = 1'b0;
    chk("err_clr", 32'(qif.err), 32'd0);
    qif.en = 1'b0;
    move(1, 0, 0, 1, 8'h01, 0, 0, "dis1");
    move(1, 1, 0, 1, 8'h01, 0, 0, "dis2");
    move(0, 1, 0, 1, 8'h01, 0, 0, "dis3");
    move(0, 0, 0, 1, 8'h01, 0, 0, "dis4");
    qif.en = 1'b1;
    move(1, 0, 1, 1, 8'h02, 0, 0, "reen");
    @(negedge clk);
    qif.a_in = 1'b1;
    qif.b_in = 1'b1;
    reset = 1'b1;
    #1;
    chk("rst2.pos", 32'(qif.pos), 32'd0);
    chk("rst2.dir", 32'(qif.dir), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("prime.step", 32'(qif.step), 32'd0);
      chk("prime.err", 32'(qif.err), 32'd0);
    end
`ifndef QDEC_FILTER_EN
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("post_prime.step", 32'(qif.step), 32'd0);
      chk("post_prime.err", 32'(qif.err), 32'd0);
    end
`else
    repeat (10) @(posedge clk);
    @(negedge clk);
    qif.err_clr = 1'b1;
    @(negedge clk);
    qif.err_clr = 1'b0;
`endif
    move(0, 1, 1, 1, 8'h01, 0, 0, "after_rst");
`ifdef QDEC_FILTER_EN
    @(negedge clk);
    qif.a_in = 1'b1;
    repeat (2) @(negedge clk);
    qif.a_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("glitch.step", 32'(qif.step), 32'd0);
      chk("glitch.pos", 32'(qif.pos), 32'h01);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
